// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register file sizing, result latencies
// (in bubbles) and performance counter width.
package pipeline_pkg;

  localparam int REG_COUNT      = 16;
  localparam int REG_ADDR_LEN   = 4;
  localparam int CNT_LEN        = 4;
  localparam int ALU_BUBBLES    = 2;
  localparam int LDR_BUBBLES    = 3;
  localparam int MULDIV_BUBBLES = 7;
  localparam int STALL_CNT_LEN  = 16;

endpackage

// File: rtl/busy_countdown.sv
// Loadable down-counter that stops at zero; a load in the same cycle
// takes priority over the decrement.
module busy_countdown #(
  parameter int CNT_LEN = pipeline_pkg::CNT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CNT_LEN-1:0] load_val,
  output logic [CNT_LEN-1:0] cnt,
  output logic               busy
);

  logic [CNT_LEN-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_LEN'(1);
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register result countdowns plus a
// mul/div busy countdown drive the RAW/WAW/structural stall request.
module hazard_scoreboard #(
  parameter int REG_COUNT      = pipeline_pkg::REG_COUNT,
  parameter int REG_ADDR_LEN   = pipeline_pkg::REG_ADDR_LEN,
  parameter int ALU_BUBBLES    = pipeline_pkg::ALU_BUBBLES,
  parameter int LDR_BUBBLES    = pipeline_pkg::LDR_BUBBLES,
  parameter int MULDIV_BUBBLES = pipeline_pkg::MULDIV_BUBBLES,
  parameter int CNT_LEN        = pipeline_pkg::CNT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_uses_src2,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_is_ldr,
  input  logic                    id_is_muldiv,
  input  logic                    flush,
  output logic                    hazard_detected,
  output logic                    issue,
  output logic [15:0]             stall_cycles
);

  localparam int SL = pipeline_pkg::STALL_CNT_LEN;

  logic [CNT_LEN-1:0]   busy_cnt [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [CNT_LEN-1:0]   md_cnt;
  logic                 md_busy;
  logic [CNT_LEN-1:0]   new_lat;
  logic                 raw;
  logic                 waw;
  logic                 strct;
  logic                 live;
  logic [SL-1:0]        stall_q;

  always_comb begin
    new_lat = CNT_LEN'(ALU_BUBBLES);
    unique case (1'b1)
      id_is_muldiv: new_lat = CNT_LEN'(MULDIV_BUBBLES);
      id_is_ldr:    new_lat = CNT_LEN'(LDR_BUBBLES);
      default:      new_lat = CNT_LEN'(ALU_BUBBLES);
    endcase
  end

  assign live  = id_valid & ~flush;
  assign raw   = busy[id_src1] | (id_uses_src2 & busy[id_src2]);
  // A younger write may not retire ahead of an older one to the same reg.
  assign waw   = id_wb_en & (busy_cnt[id_dest] > new_lat);
  assign strct = id_is_muldiv & md_busy;

  assign hazard_detected = live & (raw | waw | strct);
  assign issue           = live & ~(raw | waw | strct);

  for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
    busy_countdown #(.CNT_LEN(CNT_LEN)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (issue & id_wb_en & (id_dest == REG_ADDR_LEN'(r))),
      .load_val (new_lat),
      .cnt      (busy_cnt[r]),
      .busy     (busy[r])
    );
  end

  busy_countdown #(.CNT_LEN(CNT_LEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .load     (issue & id_is_muldiv),
    .load_val (CNT_LEN'(MULDIV_BUBBLES)),
    .cnt      (md_cnt),
    .busy     (md_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (hazard_detected && stall_q != '1) begin
      stall_q <= stall_q + SL'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Scoreboard-based hazard detection unit for the in-order pipeline; it generates the `hazard_detected` signal the decode-stage controller consumes. It tracks how many cycles remain until each register's pending result can be read, and how long the non-pipelined multiply/divide unit stays busy. It asserts `hazard_detected` when the instruction in decode must stall, which the controller converts into a bubble. It sits beside the controller in ID and is fed from the same decode fields.

## Interface
Parameters:
- `REG_COUNT`, 16, number of architectural registers.
- `REG_ADDR_LEN`, 4, register index width (clog2 of `REG_COUNT`).
- `ALU_BUBBLES`, 2, stall cycles a dependent needs after an ALU/MOVI producer.
- `LDR_BUBBLES`, 3, stall cycles after an LDR producer.
- `MULDIV_BUBBLES`, 7, stall cycles after a MUL/DIV/MOD producer; also the busy time of the mul/div unit.
- `CNT_LEN`, 4, per-register countdown width; must hold the largest bubble value.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_src1`  in  `REG_ADDR_LEN`  first source register.
- `id_src2`  in  `REG_ADDR_LEN`  second source register.
- `id_uses_src2`  in  1  instruction reads `id_src2`.
- `id_dest`  in  `REG_ADDR_LEN`  destination register.
- `id_wb_en`  in  1  instruction writes `id_dest`.
- `id_is_ldr`  in  1  instruction is a load.
- `id_is_muldiv`  in  1  instruction is MUL, DIV or MOD.
- `flush`  in  1  taken branch; the instruction in ID is discarded this cycle.
- `hazard_detected`  out  1  combinational stall request to the controller.
- `issue`  out  1  combinational; ID instruction is accepted this cycle.
- `stall_cycles`  out  16  saturating count of stall cycles, for performance monitoring.

## Operation
- Per-register state `busy_cnt[r]` (`CNT_LEN` bits).
  - Register r is busy when `busy_cnt[r] != 0`.
- Mul/div unit state `md_cnt` (`CNT_LEN` bits).
- `hazard_detected` = `id_valid & !flush & (RAW | WAW | STRUCT)`:
  - RAW: `busy[id_src1]`, or `id_uses_src2 & busy[id_src2]`.
  - WAW: `id_wb_en & busy_cnt[id_dest] > new_lat`. A younger write must never complete before an older one to the same register.
  - STRUCT: `id_is_muldiv & md_cnt != 0`.
- `new_lat` selection:
  - `MULDIV_BUBBLES` if `id_is_muldiv`.
  - else `LDR_BUBBLES` if `id_is_ldr`.
  - else `ALU_BUBBLES`.
- `issue` = `id_valid & !flush & !hazard_detected`.
- Each clock, every nonzero `busy_cnt` and `md_cnt` decrements by 1, except:
  - On `issue & id_wb_en`, `busy_cnt[id_dest]` loads `new_lat`. The load overrides the decrement.
  - On `issue & id_is_muldiv`, `md_cnt` loads `MULDIV_BUBBLES`.
- Non-writing instructions (STR, CMP, BEQ, JMP) never set a counter. They are still subject to RAW checks.
- Flush:
  - Blocks issue and forces `hazard_detected` low.
  - Does not clear any counter. Already-issued producers still complete.
- `stall_cycles` increments by 1 per cycle with `hazard_detected` high and saturates at 0xFFFF.

## Timing
- Reset: all `busy_cnt` = 0, `md_cnt` = 0, `stall_cycles` = 0.
  - `hazard_detected` and `issue` then follow the inputs, with no hazard possible.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first cycle after release behaves as an empty scoreboard.
- Producer issued in cycle t with latency L sets `busy_cnt = L` at t+1. A dependent in ID:
  - stalls in cycles t+1 through t+L;
  - issues in t+L+1.
  - Exactly L bubbles.
- Zero-latency case: if `ALU_BUBBLES` = 0, no counter is set and back-to-back dependents never stall.
- Simultaneous events: issue and decrement on the same register in one cycle means load wins.
- Outputs `hazard_detected` and `issue` are combinational from inputs and current state, with no register delay.

## Structure
- Shared package `pipeline_pkg`: `REG_ADDR_LEN`, `CNT_LEN`, the three bubble constants, and the `STALL_CNT_LEN` = 16 constant.
  - Opcode values stay in the existing defines file.
- Sub-module `busy_countdown`, one per register plus one for the mul/div unit. Each instance:
  - has inputs `clk`, `rst`, `load`, `load_val`;
  - has outputs `cnt`, `busy`;
  - implements load-priority over decrement-to-zero.

## Test plan
- Reset, then ADD r1 followed by ADD r2,r1: `hazard_detected` high for exactly 2 cycles, `issue` in the 3rd, `stall_cycles` = 2.
- LDR r3 then STR using r3 as `id_src2` with `id_uses_src2` = 1: 3 stall cycles. Same STR with `id_uses_src2` = 0: no stall.
- DIV r4 then an independent MUL r5: STRUCT stall of 7 cycles. An independent ADD r6 right after the DIV issues with no stall.
- DIV r7 (latency 7) then ADD r7 (latency 2): WAW stall until `busy_cnt[7]` ≤ 2, which is 5 stall cycles.
- `flush` pulsed while a RAW stall is pending: `hazard_detected` = 0 and `issue` = 0 that cycle. The counter continues, and the stall resumes the next cycle if the instruction is re-presented.
- Assert `rst` low mid-countdown after LDR r3: all counters clear. After release, a dependent on r3 issues immediately.
